// File: rtl/miss_handler_q.sv
// rtl/miss_handler_q.sv - queued cache line-miss handler feeding SDRAM bursts
`timescale 1ns/1ps
`ifndef maxTrans
`define maxTrans 64
`endif

module miss_handler_q #(
  parameter int          LINE_W    = 64,
  parameter int          TAG_W     = 3,
  parameter int          INDEX_W   = 4,
  parameter int          DEPTH     = 4,
  parameter logic [24:0] BASE_ADDR = 25'd0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [24:0]                      addr_cache_to_sdram,
  output logic [$clog2(`maxTrans)-1:0]     transSize,
  output logic                             readReq,
  input  logic                             readValid_out,
  input  logic [31:0]                      readData,
  input  logic                             doneRead,
  input  logic [TAG_W+INDEX_W-1:0]         to_mh_addr,
  input  logic                             to_mh_valid,
  output logic                             from_mh_stall,
  output logic [LINE_W-1:0]                from_mh_data,
  output logic [TAG_W+INDEX_W-1:0]         from_mh_addr,
  output logic                             from_mh_valid,
  input  logic                             to_mh_stall,
  output logic [$clog2(DEPTH+1)-1:0]       mh_pending
);

  localparam int NUM_REQ = LINE_W / 32;
  localparam int AW      = TAG_W + INDEX_W;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW      = $clog2(NUM_REQ + 1);
  localparam int TW      = $clog2(`maxTrans);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  if ((LINE_W <= 0) || (LINE_W % 32 != 0)) begin : g_bad_line_w
    $fatal(1, "miss_handler_q: LINE_W must be a positive multiple of 32");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "miss_handler_q: DEPTH must be at least 2");
  end

  logic [1:0]        r_state;
  logic [AW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [AW-1:0]     r_last;
  logic [AW-1:0]     r_cur;
  logic [BW-1:0]     r_beat;
  logic [LINE_W-1:0] r_line;
  logic [24:0]       r_saddr;

  logic              w_full;
  logic              w_dup;
  logic              w_enq;
  logic              w_pop;
  logic              w_beat_wr;
  logic [AW-1:0]     w_head;
  logic [24:0]       w_xlat;

  assign w_full = (r_count == CW'(DEPTH));
  // r_last is only meaningful while something is queued: it is then the tail entry.
  assign w_dup  = ((r_count != '0) && (to_mh_addr == r_last)) ||
                  ((r_state != S_IDLE) && (to_mh_addr == r_cur));
  assign w_enq  = to_mh_valid && !w_full && !w_dup;
  assign w_pop  = (r_count != '0) &&
                  ((r_state == S_IDLE) || ((r_state == S_HOLD) && !to_mh_stall));
  assign w_head = r_mem[r_rptr];
  assign w_xlat = BASE_ADDR + 25'(w_head) * 25'(NUM_REQ);
  assign w_beat_wr = (r_state == S_XFER) && readValid_out && (r_beat < BW'(NUM_REQ));

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wptr] <= to_mh_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
        r_last <= to_mh_addr;
      end
      if (w_pop) r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      r_count <= r_count + CW'(w_enq) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_saddr <= '0;
      r_beat  <= '0;
      r_line  <= '0;
    end else begin
      if (w_pop) begin
        r_cur   <= w_head;
        r_saddr <= w_xlat;
        r_beat  <= '0;
      end
      // Beats past the end of the line saturate the counter and are dropped.
      if (w_beat_wr) begin
        r_beat <= r_beat + 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (r_beat == BW'(i)) r_line[LINE_W-1-32*i -: 32] <= readData;
        end
      end
      case (r_state)
        S_IDLE:  if (w_pop) r_state <= S_REQ;
        S_REQ:   r_state <= S_XFER;
        S_XFER:  if (doneRead) r_state <= S_HOLD;
        default: if (!to_mh_stall) r_state <= w_pop ? S_REQ : S_IDLE;
      endcase
    end
  end

  assign readReq             = (r_state == S_REQ) || (r_state == S_XFER);
  assign from_mh_valid       = (r_state == S_HOLD);
  assign from_mh_stall       = w_full;
  assign mh_pending          = r_count;
  assign from_mh_data        = r_line;
  assign from_mh_addr        = r_cur;
  assign addr_cache_to_sdram = r_saddr;
  assign transSize           = TW'(NUM_REQ);

endmodule
